popcount_seq_ctrl: RTL
======================

POPCOUNT_SEQ_CTRL -- requirements
Module: popcount_seq_ctrl

Parameters
REQ-001 The block SHALL have parameter NSLICE, default 8, giving the number of 7-bit slices per input word (word width W = 7*NSLICE).
REQ-002 The block SHALL derive localparams LW = clog2(NSLICE+1) as the length-field width and CW = clog2(7*NSLICE+1) as the count width (4 and 6 at the default).

Interface
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  request word present.
REQ-006 in_ready  output  1  block can accept a request word.
REQ-007 in_data  input  W  word to count; slice k = in_data[7k+6:7k].
REQ-008 in_len  input  LW  number of low slices to count.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_count  output  CW  number of set bits in the counted slices.
REQ-012 busy  output  1  high in RUN state.

Function
REQ-013 The block SHALL contain exactly one 7-input popcount slice (7 bits in, 3-bit sum out), time-shared across slices, one slice per clock.
REQ-014 The block SHALL implement the states IDLE, RUN and DONE.
REQ-015 Accept SHALL occur on an edge where in_valid and in_ready are both 1; on accept, in_data is captured into a shift register and the length is captured as L = min(in_len, NSLICE); the accumulator clears.
REQ-016 in_ready SHALL be 1 when the state is IDLE, or when the state is DONE and out_ready=1; it is 0 otherwise, including whenever rst_n=0.
REQ-017 IDLE -> RUN on accept with L>0; IDLE -> DONE on accept with L=0, giving out_count=0.
REQ-018 In RUN, each edge SHALL add the popcount of the current lowest slice to the accumulator, shift the register right by 7 and decrement the remaining-slice counter.
REQ-019 RUN -> DONE on the edge that processes the L-th slice; slices at index >= L never contribute.
REQ-020 Latency from the accept edge to the first cycle with out_valid=1 SHALL be max(L,1) cycles.
REQ-021 In DONE, out_valid=1 and out_count SHALL hold stable until an edge with out_ready=1.
REQ-022 DONE with out_ready=1 and no accept -> IDLE.
REQ-023 DONE with out_ready=1 and an accept on the same edge -> RUN, or DONE if the new L=0, with no idle bubble between results.
REQ-024 out_valid SHALL be 0 in IDLE and RUN, and busy SHALL equal (state==RUN).
REQ-025 The accumulator is CW bits wide and cannot overflow (maximum 7*NSLICE); slice sums SHALL be zero-extended before the add.
REQ-026 in_data and in_len SHALL be ignored except on accept edges; changes to them during RUN or DONE have no effect.
REQ-027 out_count SHALL be 0 outside DONE.

Reset
REQ-028 On an edge with rst_n=0 the block SHALL go to IDLE and clear the accumulator, shift register and slice counter, giving out_valid=0, out_count=0 and busy=0.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL discard the in-flight request, and no out_valid for it ever appears.
REQ-030 In the first cycle after rst_n returns to 1, in_ready SHALL be 1.

Verification
REQ-031 Reset scenario: rst_n=0 for 2 cycles -> in_ready=0, out_valid=0, busy=0, out_count=0; after release, in_ready=1.
REQ-032 Full-word scenario: in_data all ones, in_len=8, out_ready=1 -> busy for 8 cycles, out_valid high 8 cycles after accept, out_count=56.
REQ-033 Partial-length scenario: in_len=3, slice0=7'h7F, slice1=7'h01, slice2=7'h00, slices 3-7 all ones -> out_count=8, out_valid 3 cycles after accept.
REQ-034 Length-boundary scenario: in_len=0 -> out_count=0 one cycle after accept, with busy never high; in_len=12 with all-ones data -> treated as 8, out_count=56.
REQ-035 Backpressure and back-to-back scenario: out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_count stable, in_ready=0; then out_ready=1 and in_valid=1 on the same edge with in_len=1, slice0=7'h55 -> next cycle busy=1, then out_count=4.
REQ-036 Mid-operation reset scenario: rst_n=0 on the 4th RUN cycle of an in_len=8 request -> IDLE next cycle, no out_valid; a following in_len=1, slice0=7'h03 request -> out_count=2.

Source files
------------

// File: rtl/popcount_seq_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : popcount_seq_ctrl_if
// Brief    : Request/result handshake bundle for the sequential popcount block.
// Revision : 1.0
// =============================================================================
interface popcount_seq_ctrl_if #(
    parameter int NSLICE = 8
);
    localparam int W  = 7 * NSLICE;
    localparam int LW = $clog2(NSLICE + 1);
    localparam int CW = $clog2(7 * NSLICE + 1);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [LW-1:0] in_len;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic          busy;

    modport master (
        output in_valid, in_data, in_len, out_ready,
        input  in_ready, out_valid, out_count, busy
    );

    modport slave (
        input  in_valid, in_data, in_len, out_ready,
        output in_ready, out_valid, out_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/popcount_seq_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : popcount_seq_ctrl
// Brief    : Counts set bits in the low L 7-bit slices of a word, one slice/clock.
// Revision : 1.0
// =============================================================================
module popcount_seq_ctrl #(
    parameter int NSLICE = 8
) (
    input  wire                clk,
    input  wire                rst_n,
    popcount_seq_ctrl_if.slave bus
);
    localparam int W  = 7 * NSLICE;
    localparam int LW = $clog2(NSLICE + 1);
    localparam int CW = $clog2(7 * NSLICE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [W-1:0]  r_shift;
    logic [LW-1:0] r_remain;
    logic [CW-1:0] r_acc;

    logic          w_accept;
    logic [LW-1:0] w_len_cap;
    logic [6:0]    w_slice;
    logic [2:0]    w_pop;

    // in_ready is forced low combinationally while reset is held
    assign bus.in_ready  = rst_n && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_len_cap     = (bus.in_len > LW'(NSLICE)) ? LW'(NSLICE) : bus.in_len;

    assign bus.out_valid = (r_state == DONE);
    assign bus.out_count = (r_state == DONE) ? r_acc : '0;
    assign bus.busy      = (r_state == RUN);

    // The single shared 7-input popcount slice
    assign w_slice = r_shift[6:0];
    always_comb begin
        w_pop = 3'd0;
        for (int i = 0; i < 7; i++) begin
            w_pop = w_pop + {2'b00, w_slice[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_len_cap == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_remain == LW'(1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_state_next = (w_len_cap == '0) ? DONE : RUN;
                end else if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_remain <= '0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_shift  <= bus.in_data;
            r_remain <= w_len_cap;
            r_acc    <= '0;
        end else if (r_state == RUN) begin
            r_shift  <= r_shift >> 7;
            r_remain <= r_remain - LW'(1);
            r_acc    <= r_acc + CW'(w_pop);
        end
    end
endmodule
`default_nettype wire
